// File: rtl/exu_pkg.sv
//------------------------------------------------------------------------------
// Module  : exu_pkg
// Brief   : Shared types for the execute stage: ALU opcodes and result entry.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package exu_pkg;

    localparam int unsigned c_xlen = 32;
    localparam int unsigned c_rd_w = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_SLL   = 4'h2,
        ALU_SLT   = 4'h3,
        ALU_SLTU  = 4'h4,
        ALU_XOR   = 4'h5,
        ALU_SRL   = 4'h6,
        ALU_SRA   = 4'h7,
        ALU_OR    = 4'h8,
        ALU_AND   = 4'h9,
        ALU_PASS2 = 4'hA
    } alu_op_e;

    typedef struct packed {
        logic [c_xlen-1:0] result;
        logic [c_rd_w-1:0] rd;
        logic              rf_wen;
        logic              illegal;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/exu_alu_core.sv
//------------------------------------------------------------------------------
// Module  : exu_alu_core
// Brief   : Combinational integer ALU; flags opcodes outside alu_op_e as illegal.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exu_alu_core
    import exu_pkg::*;
#(
    parameter int unsigned XLEN = c_xlen
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int unsigned c_shw = $clog2(XLEN);

    logic [c_shw-1:0] w_shamt;

    assign w_shamt = src2[c_shw-1:0];

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            ALU_ADD:   result = src1 + src2;
            ALU_SUB:   result = src1 - src2;
            ALU_SLL:   result = src1 << w_shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (src1 < src2)};
            ALU_XOR:   result = src1 ^ src2;
            ALU_SRL:   result = src1 >> w_shamt;
            ALU_SRA:   result = $unsigned($signed(src1) >>> w_shamt);
            ALU_OR:    result = src1 | src2;
            ALU_AND:   result = src1 & src2;
            ALU_PASS2: result = src2;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exu_alu_stage.sv
//------------------------------------------------------------------------------
// Module  : exu_alu_stage
// Brief   : Execute stage: ALU on the input side feeding a 2-entry skid buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exu_alu_stage
    import exu_pkg::*;
#(
    parameter int unsigned XLEN = c_xlen,
    parameter int unsigned RD_W = c_rd_w
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_rf_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_rf_wen,
    output logic            out_illegal
);

    // State bits are {main_valid, skid_valid}
    localparam logic [1:0] c_empty = 2'b00;
    localparam logic [1:0] c_one   = 2'b10;
    localparam logic [1:0] c_full  = 2'b11;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_in_ready;
    entry_t          r_main;
    entry_t          r_skid;
    entry_t          w_new;
    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_illegal;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_load_main_new;
    logic            w_load_main_skid;
    logic            w_load_skid;

    exu_alu_core #(
        .XLEN (XLEN)
    ) u_alu (
        .op      (in_op),
        .src1    (in_src1),
        .src2    (in_src2),
        .result  (w_alu_result),
        .illegal (w_alu_illegal)
    );

    assign w_new.result  = w_alu_result;
    assign w_new.rd      = in_rd;
    assign w_new.rf_wen  = in_rf_wen & ~w_alu_illegal;
    assign w_new.illegal = w_alu_illegal;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_state[1] & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = c_empty;
        end else begin
            case (r_state)
                c_one: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_new = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = c_full;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = c_empty;
                    end
                end
                c_full: begin
                    if (w_out_fire) begin
                        w_state_nxt      = c_one;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    if (w_in_fire) begin
                        w_state_nxt     = c_one;
                        w_load_main_new = 1'b1;
                    end
                end
            endcase
        end
    end

    // in_ready is registered from the next skid state so it never sees out_ready combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_empty;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= ~w_state_nxt[0];
            if (w_load_main_new) begin
                r_main <= w_new;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_new;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_state[1];
    assign out_result  = r_main.result;
    assign out_rd      = r_main.rd;
    assign out_rf_wen  = r_main.rf_wen;
    assign out_illegal = r_main.illegal;

endmodule

`default_nettype wire

// File: tb/tb_exu_alu_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_exu_alu_stage
// Brief   : Randomized bench for exu_alu_stage against a queue-based reference.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_exu_alu_stage;
    import exu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_rf_wen;
    logic        out_valid, out_ready, out_rf_wen, out_illegal;
    logic [3:0]  in_op;
    logic [31:0] in_src1, in_src2, out_result;
    logic [4:0]  in_rd, out_rd;

    always #5 clk = ~clk;

    exu_alu_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_rf_wen(in_rf_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_rf_wen(out_rf_wen), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   ready_ok  = 1'b0;
    bit   zero_outs = 1'b1;
    bit   live      = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLL:   return a << sh;
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   return a ^ b;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return $signed(a) >>> sh;
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_PASS2: return b;
            default:   return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: up to two ops in flight, strictly in order
    always @(posedge clk) begin
        bit   of, inf;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            ready_ok  = 1'b0;
            zero_outs = 1'b1;
        end else begin
            of  = (q.size() > 0) && out_ready;
            inf = in_valid && ready_ok && (q.size() < 2);
            if (of) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (inf) begin
                e.ill = (in_op > 4'hA);
                e.res = alu_ref(in_op, in_src1, in_src2);
                e.rd  = in_rd;
                e.wen = in_rf_wen && !e.ill;
                q.push_back(e);
                zero_outs = 1'b0;
            end
            ready_ok = 1'b1;
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, ready_ok && (q.size() < 2));
            if (q.size() > 0) begin
                chk("out_result", out_result, q[0].res);
                chk("out_rd", out_rd, q[0].rd);
                chk("out_rf_wen", out_rf_wen, q[0].wen);
                chk("out_illegal", out_illegal, q[0].ill);
            end else if (zero_outs) begin
                chk("rst_result", out_result, 0);
                chk("rst_rd", out_rd, 0);
                chk("rst_rf_wen", out_rf_wen, 0);
                chk("rst_illegal", out_illegal, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand();
        in_op     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 10));
        in_src1   = rand_word();
        in_src2   = rand_word();
        in_rd     = 5'($urandom);
        in_rf_wen = 1'($urandom);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        in_rd = 5'd7; in_rf_wen = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1);
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        chk("rel_in_ready_low", in_ready, 0);
        step();
        chk("rel_in_ready_high", in_ready, 1);

        out_ready = 1'b1;
        drive(ALU_SRA, 32'h8000_00F0, 32'd4);     step(); chk("sra4", out_result, 32'hF800_000F);
        drive(ALU_SRL, 32'h8000_00F0, 32'd4);     step(); chk("srl4", out_result, 32'h0800_000F);
        drive(ALU_SRA, 32'h8000_00F0, 32'h25);    step(); chk("sra25", out_result, 32'hFC00_0007);
        drive(ALU_SRL, 32'h8000_00F0, 32'h25);    step(); chk("srl25", out_result, 32'h0400_0007);
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);     step(); chk("slt", out_result, 32'd1);
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);    step(); chk("sltu", out_result, 32'd0);
        drive(4'hF, 32'h1234_5678, 32'h9ABC_DEF0); step();
        chk("ill_flag", out_illegal, 1);
        chk("ill_wen", out_rf_wen, 0);
        chk("ill_result", out_result, 0);
        in_valid = 1'b0; step();

        // backpressure: two accepted, third stalls
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd2);     step();
        drive(ALU_ADD, 32'd10, 32'd20);   step();
        drive(ALU_ADD, 32'd100, 32'd200);
        chk("bp_full_ready", in_ready, 0);
        step();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_result", out_result, 32'd3);
        out_ready = 1'b1;
        step(); chk("bp_second", out_result, 32'd30);
        step(); chk("bp_third", out_result, 32'd300);
        in_valid = 1'b0;
        step(); chk("bp_drained", out_valid, 0);

        // streaming: one result per cycle
        for (int i = 0; i < 100; i++) begin
            drive_rand(); in_valid = 1'b1;
            step();
            chk("stream_valid", out_valid, 1);
        end
        in_valid = 1'b0; step();

        // flush while FULL with an incoming op
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd5, 32'd6); step();
        drive(ALU_ADD, 32'd7, 32'd8); step();
        chk("fl_full", in_ready, 0);
        flush = 1'b1; drive(ALU_PASS2, 32'd0, 32'hDEAD_BEEF);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) begin step(); chk("fl_no_ghost", out_valid, 0); end

        // flush in ONE with an accepted op in the same cycle
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd9, 32'd9); step();
        flush = 1'b1; drive(ALU_PASS2, 32'd0, 32'hCAFE_F00D);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_valid", out_valid, 0);
        step(); chk("fl1_no_ghost", out_valid, 0);

        // random mix of traffic, backpressure and flushes
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step();
        end
        flush = 1'b0;

        // reset while FULL discards everything
        out_ready = 1'b0;
        drive(ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0); step();
        drive(ALU_OR, 32'h1, 32'h2); step();
        rst_n = 1'b0; step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", out_result, 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("mid_rst_after", out_valid, 0);

        for (int i = 0; i < 30; i++) begin
            drive_rand();
            in_valid = ($urandom_range(0, 1) != 0);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("final_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
